exc_ctrl: RTL and testbench

Exception controller in the MEM stage, directly upstream of the CP0 register file. Each cycle it:
- merges the MEM-stage exception flags with the pending-interrupt condition, using CP0 Status/Cause/EPC bypassed from the WB-stage CP0 write;
- drives the exception type, instruction address and delay-slot flag that CP0 samples on the next edge;
- issues a registered pipeline flush with the handler or ERET target PC, then blocks new exceptions for a fixed flush window.

---
 rtl/exc_ctrl_pkg.sv | 39 +++
 rtl/exc_prio_enc.sv | 30 +++
 rtl/exc_ctrl.sv | 112 +++++++++++
 tb/tb_exc_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the MEM-stage exception controller: CP0 register
// addresses, exception codes, flag bit positions and controller states.
package exc_ctrl_pkg;

  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  localparam logic [31:0] EXC_NONE = 32'h0000_0000;
  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_INV  = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam int FLAG_W    = 5;
  localparam int FLAG_INV  = 0;
  localparam int FLAG_SYS  = 1;
  localparam int FLAG_TRAP = 2;
  localparam int FLAG_OV   = 3;
  localparam int FLAG_ERET = 4;

  localparam int CNT_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } exc_state_e;

  // Interrupts are masked while EXL is set or IE is clear.
  function automatic logic int_pending(input logic       ie,
                                       input logic       exl,
                                       input logic [7:0] im,
                                       input logic [7:0] ip);
    return ie && !exl && ((ip & im) != 8'h00);
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder turning the interrupt condition and MEM flags into
// the CP0 exception code; yields zero when the cycle may not take exceptions.
module exc_prio_enc
  import exc_ctrl_pkg::*;
(
  input  logic [FLAG_W-1:0] flags,
  input  logic              int_pend,
  input  logic              eligible,
  output logic [31:0]       code
);

  always_comb begin
    code = EXC_NONE;
    if (eligible) begin
      if (int_pend)
        code = EXC_INT;
      else if (flags[FLAG_INV])
        code = EXC_INV;
      else if (flags[FLAG_SYS])
        code = EXC_SYS;
      else if (flags[FLAG_TRAP])
        code = EXC_TRAP;
      else if (flags[FLAG_OV])
        code = EXC_OV;
      else if (flags[FLAG_ERET])
        code = EXC_ERET;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// MEM-stage exception controller: bypasses pending WB writes to CP0, picks
// the exception to hand to CP0 and issues a registered flush with target PC.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid_i,
  input  logic              mem_stall_i,
  input  logic [31:0]       mem_inst_addr_i,
  input  logic              mem_in_delayslot_i,
  input  logic [FLAG_W-1:0] mem_exc_flags_i,
  input  logic [31:0]       cp0_status_i,
  input  logic [31:0]       cp0_cause_i,
  input  logic [31:0]       cp0_epc_i,
  input  logic              wb_cp0_we_i,
  input  logic [4:0]        wb_cp0_waddr_i,
  input  logic [31:0]       wb_cp0_data_i,
  output logic [31:0]       excepttype_o,
  output logic [31:0]       cur_inst_addr_o,
  output logic              is_in_delayslot_o,
  output logic              kill_o,
  output logic              flush_o,
  output logic [31:0]       new_pc_o
);

  exc_state_e       state;
  logic [CNT_W-1:0] cnt;

  logic [31:0] eff_status;
  logic [31:0] eff_cause;
  logic [31:0] eff_epc;
  logic        int_pend;
  logic        eligible;
  logic [31:0] target;
  logic        unused_bits;

  // Only the software-writable Cause fields (IP1..IP0, IV, WP) take the bypass.
  always_comb begin
    eff_status = cp0_status_i;
    eff_cause  = cp0_cause_i;
    eff_epc    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      case (wb_cp0_waddr_i)
        CP0_REG_STATUS: eff_status = wb_cp0_data_i;
        CP0_REG_CAUSE: begin
          eff_cause[9:8] = wb_cp0_data_i[9:8];
          eff_cause[23]  = wb_cp0_data_i[23];
          eff_cause[22]  = wb_cp0_data_i[22];
        end
        CP0_REG_EPC:    eff_epc = wb_cp0_data_i;
        default: ;
      endcase
    end
  end

  assign unused_bits = ^{eff_status[31:16], eff_status[7:2],
                         eff_cause[31:16], eff_cause[7:0]};

  assign int_pend = int_pending(eff_status[0], eff_status[1],
                                eff_status[15:8], eff_cause[15:8]);
  assign eligible = (state == ST_IDLE) && mem_valid_i && !mem_stall_i;

  exc_prio_enc u_prio (
    .flags    (mem_exc_flags_i),
    .int_pend (int_pend),
    .eligible (eligible),
    .code     (excepttype_o)
  );

  assign target            = (excepttype_o == EXC_ERET) ? eff_epc : EXC_VECTOR;
  assign kill_o            = (excepttype_o != EXC_NONE) || (state == ST_FLUSH);
  assign cur_inst_addr_o   = mem_inst_addr_i;
  assign is_in_delayslot_o = mem_in_delayslot_i;

  // Flush window: cnt counts the remaining flush cycles after the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      flush_o  <= 1'b0;
      new_pc_o <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (excepttype_o != EXC_NONE) begin
            state    <= ST_FLUSH;
            cnt      <= CNT_W'(FLUSH_CYCLES - 1);
            flush_o  <= 1'b1;
            new_pc_o <= target;
          end
        end
        ST_FLUSH: begin
          if (cnt == '0) begin
            state   <= ST_IDLE;
            flush_o <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          flush_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboarded bench for exc_ctrl: directed scenarios followed by a random
// phase, all checked against an independent cycle model.
module tb_exc_ctrl;

  localparam logic [31:0] VEC = 32'h0000_0020;
  localparam int          FC  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_i, mem_stall_i, mem_in_delayslot_i;
  logic [31:0] mem_inst_addr_i;
  logic [4:0]  mem_exc_flags_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;
  logic [31:0] excepttype_o, cur_inst_addr_o, new_pc_o;
  logic        is_in_delayslot_o, kill_o, flush_o;

  always #5 clk = ~clk;

  exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk                (clk),
    .rst                (rst),
    .mem_valid_i        (mem_valid_i),
    .mem_stall_i        (mem_stall_i),
    .mem_inst_addr_i    (mem_inst_addr_i),
    .mem_in_delayslot_i (mem_in_delayslot_i),
    .mem_exc_flags_i    (mem_exc_flags_i),
    .cp0_status_i       (cp0_status_i),
    .cp0_cause_i        (cp0_cause_i),
    .cp0_epc_i          (cp0_epc_i),
    .wb_cp0_we_i        (wb_cp0_we_i),
    .wb_cp0_waddr_i     (wb_cp0_waddr_i),
    .wb_cp0_data_i      (wb_cp0_data_i),
    .excepttype_o       (excepttype_o),
    .cur_inst_addr_o    (cur_inst_addr_o),
    .is_in_delayslot_o  (is_in_delayslot_o),
    .kill_o             (kill_o),
    .flush_o            (flush_o),
    .new_pc_o           (new_pc_o)
  );

  typedef struct {
    logic [31:0] etype;
    logic        kill;
    logic        flush;
    logic [31:0] npc;
    logic [31:0] addr;
    logic        ds;
  } exp_t;

  exp_t sbq[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Model: remaining flush cycles (0 = idle) and the redirect register.
  int          m_left = 0;
  logic        m_flush = 1'b0;
  logic [31:0] m_npc = 32'h0;

  logic [31:0] o_etype, o_npc;
  logic        o_kill, o_flush, o_ds;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_epc();
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) return wb_cp0_data_i;
    return cp0_epc_i;
  endfunction

  function automatic logic [31:0] ref_code();
    logic [31:0] st, ca;
    logic        irq;
    st = (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) ? wb_cp0_data_i : cp0_status_i;
    ca = cp0_cause_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) ca[9:8] = wb_cp0_data_i[9:8];
    irq = st[0] && !st[1] && ((st[15:8] & ca[15:8]) != 8'h0);
    if (m_left != 0 || !mem_valid_i || mem_stall_i) return 32'h0;
    if (irq)                 return 32'h1;
    if (mem_exc_flags_i[0])  return 32'ha;
    if (mem_exc_flags_i[1])  return 32'h8;
    if (mem_exc_flags_i[2])  return 32'hd;
    if (mem_exc_flags_i[3])  return 32'hc;
    if (mem_exc_flags_i[4])  return 32'he;
    return 32'h0;
  endfunction

  task automatic step(input string tag);
    exp_t        e;
    logic [31:0] code, tgt;
    code    = ref_code();
    tgt     = (code == 32'he) ? ref_epc() : VEC;
    e.etype = code;
    e.kill  = (code != 0) || (m_left != 0);
    e.flush = m_flush;
    e.npc   = m_npc;
    e.addr  = mem_inst_addr_i;
    e.ds    = mem_in_delayslot_i;
    sbq.push_back(e);
    @(negedge clk);
    e       = sbq.pop_front();
    o_etype = excepttype_o;
    o_kill  = kill_o;
    o_flush = flush_o;
    o_npc   = new_pc_o;
    o_ds    = is_in_delayslot_o;
    check({tag, "/type"},  excepttype_o,             e.etype);
    check({tag, "/kill"},  {31'h0, kill_o},          {31'h0, e.kill});
    check({tag, "/flush"}, {31'h0, flush_o},         {31'h0, e.flush});
    check({tag, "/npc"},   new_pc_o,                 e.npc);
    check({tag, "/addr"},  cur_inst_addr_o,          e.addr);
    check({tag, "/ds"},    {31'h0, is_in_delayslot_o}, {31'h0, e.ds});
    @(posedge clk);
    if (rst) begin
      m_left = 0; m_flush = 1'b0; m_npc = 32'h0;
    end else if (m_left != 0) begin
      m_left--;
      m_flush = (m_left != 0);
    end else if (code != 0) begin
      m_left = FC; m_flush = 1'b1; m_npc = tgt;
    end
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; mem_valid_i = 1'b0; mem_stall_i = 1'b0; mem_in_delayslot_i = 1'b0;
    mem_inst_addr_i = 32'h0; mem_exc_flags_i = 5'b0;
    cp0_status_i = 32'h0; cp0_cause_i = 32'h0; cp0_epc_i = 32'h0;
    wb_cp0_we_i = 1'b0; wb_cp0_waddr_i = 5'd0; wb_cp0_data_i = 32'h0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    step("reset");
    check("reset/flush0", {31'h0, o_flush}, 32'h0);
    check("reset/npc0",   o_npc,            32'h0);
    check("reset/kill0",  {31'h0, o_kill},  32'h0);

    // Syscall
    mem_valid_i = 1'b1; mem_inst_addr_i = 32'h100; mem_exc_flags_i = 5'b00010;
    step("sys_t");
    check("sys/code", o_etype, 32'h8);
    check("sys/kill", {31'h0, o_kill}, 32'h1);
    idle_inputs();
    step("sys_t1");
    check("sys/npc1", o_npc, 32'h20);
    step("sys_t2");
    check("sys/flush2", {31'h0, o_flush}, 32'h1);
    step("sys_t3");
    check("sys/flush3", {31'h0, o_flush}, 32'h0);

    // Interrupt beats ERET, delay slot passes through
    mem_valid_i = 1'b1; mem_inst_addr_i = 32'h204; mem_in_delayslot_i = 1'b1;
    cp0_status_i = 32'h0000_0401; cp0_cause_i = 32'h0000_0400; cp0_epc_i = 32'h40;
    mem_exc_flags_i = 5'b10000;
    step("int_t");
    check("int/code", o_etype, 32'h1);
    check("int/ds",   {31'h0, o_ds}, 32'h1);
    idle_inputs();
    step("int_t1");
    check("int/npc", o_npc, 32'h20);
    step("int_t2");
    step("int_t3");

    // ERET with EPC bypassed from WB
    mem_valid_i = 1'b1; mem_inst_addr_i = 32'h300; cp0_epc_i = 32'h40;
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h200;
    mem_exc_flags_i = 5'b10000;
    step("eret_t");
    check("eret/code", o_etype, 32'he);
    idle_inputs();
    step("eret_t1");
    check("eret/npc", o_npc, 32'h200);
    step("eret_t2");
    step("eret_t3");

    // Bubbles and stalls hold off a pending interrupt
    cp0_status_i = 32'h0000_0401; cp0_cause_i = 32'h0000_0400;
    for (int i = 0; i < 3; i++) begin
      step("bub");
      check("bub/code", o_etype, 32'h0);
    end
    mem_valid_i = 1'b1; mem_stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step("stall");
      check("stall/code", o_etype, 32'h0);
    end
    mem_stall_i = 1'b0;
    step("stall_go");
    check("stall/taken", o_etype, 32'h1);
    idle_inputs();
    step("stall_f1");
    step("stall_f2");

    // Flush window blocks back-to-back exceptions
    mem_valid_i = 1'b1; mem_exc_flags_i = 5'b01000;
    step("win_t");
    check("win/ov", o_etype, 32'hc);
    mem_exc_flags_i = 5'b00001;
    step("win_t1");
    check("win/blk1", o_etype, 32'h0);
    check("win/kill1", {31'h0, o_kill}, 32'h1);
    step("win_t2");
    check("win/blk2", o_etype, 32'h0);
    step("win_t3");
    check("win/inv", o_etype, 32'ha);
    idle_inputs();
    step("win_f1");
    step("win_f2");

    // Reset during flush
    mem_valid_i = 1'b1; mem_exc_flags_i = 5'b00010;
    step("rst_t");
    idle_inputs();
    rst = 1'b1;
    step("rst_t1");
    rst = 1'b0; mem_valid_i = 1'b1; mem_exc_flags_i = 5'b00010;
    step("rst_t2");
    check("rst/flush", {31'h0, o_flush}, 32'h0);
    check("rst/npc",   o_npc, 32'h0);
    check("rst/sys",   o_etype, 32'h8);
    idle_inputs();
    step("rst_f1");
    step("rst_f2");

    // WB clears IE in the same cycle: no interrupt
    mem_valid_i = 1'b1; cp0_status_i = 32'h0000_0401; cp0_cause_i = 32'h0000_0400;
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd12; wb_cp0_data_i = 32'h0000_0400;
    step("ieclr");
    check("ieclr/code", o_etype, 32'h0);
    // Cause bypass: IP0 from WB counts, IP2 from WB does not
    cp0_status_i = 32'h0000_0501; cp0_cause_i = 32'h0;
    wb_cp0_waddr_i = 5'd13; wb_cp0_data_i = 32'h0000_0400;
    step("cause_hw");
    check("cause/hw", o_etype, 32'h0);
    wb_cp0_data_i = 32'h0000_0100;
    step("cause_sw");
    check("cause/sw", o_etype, 32'h1);
    idle_inputs();
    step("cause_f1");
    step("cause_f2");

    // Random phase
    for (int i = 0; i < 300; i++) begin
      rst                = ($urandom_range(39) == 0);
      mem_valid_i        = ($urandom_range(3) != 0);
      mem_stall_i        = ($urandom_range(3) == 0);
      mem_in_delayslot_i = 1'($urandom_range(1));
      mem_inst_addr_i    = $urandom & 32'hffff_fffc;
      mem_exc_flags_i    = ($urandom_range(2) == 0) ? 5'b0 : 5'($urandom);
      case ($urandom_range(3))
        0: cp0_status_i = 32'h0;
        1: cp0_status_i = 32'h0000_0401;
        2: cp0_status_i = 32'h0000_ff03;
        default: cp0_status_i = 32'h0000_0101;
      endcase
      cp0_cause_i    = ($urandom_range(1) == 0) ? 32'h0 : 32'h0000_0400;
      cp0_epc_i      = $urandom;
      wb_cp0_we_i    = ($urandom_range(3) == 0);
      case ($urandom_range(3))
        0: wb_cp0_waddr_i = 5'd12;
        1: wb_cp0_waddr_i = 5'd13;
        2: wb_cp0_waddr_i = 5'd14;
        default: wb_cp0_waddr_i = 5'd5;
      endcase
      wb_cp0_data_i  = $urandom;
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
